// File: rtl/ili9341_spi_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ili9341_spi_receiver
// Brief    : Decodes the ILI9341 SPI stream (CASET/PASET/RAMWR) into pixels.
// Revision : 1.0 - initial release
// ============================================================================
module ili9341_spi_receiver #(
  parameter int H_RES = 240,
  parameter int V_RES = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_cs,
  input  logic        spi_dc,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        frame_done,
  output logic        win_err
);

  localparam logic [7:0]  CMD_CASET = 8'h2A;
  localparam logic [7:0]  CMD_PASET = 8'h2B;
  localparam logic [7:0]  CMD_RAMWR = 8'h2C;
  localparam logic [15:0] H_LIMIT   = 16'(H_RES);
  localparam logic [15:0] V_LIMIT   = 16'(V_RES);
  localparam logic [8:0]  H_LAST    = 9'(H_RES - 1);
  localparam logic [8:0]  V_LAST    = 9'(V_RES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CASET = 2'd1,
    ST_PASET = 2'd2,
    ST_RAMWR = 2'd3
  } state_t;

  // Synchronizer lanes: [0]=sck, [1]=mosi, [2]=cs, [3]=dc
  logic [3:0] sync1_q, sync2_q;
  logic       sck_prev_q;
  logic       sck_s, mosi_s, cs_s, dc_s, sck_rise;

  state_t      state_q, state_d;
  logic [6:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  param_idx_q, param_idx_d;
  logic [23:0] param_buf_q, param_buf_d;
  logic        hi_pending_q, hi_pending_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic [8:0]  col_start_q, col_start_d, col_end_q, col_end_d;
  logic [8:0]  row_start_q, row_start_d, row_end_q, row_end_d;
  logic [8:0]  col_ptr_q, col_ptr_d, row_ptr_q, row_ptr_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_code_q, cmd_code_d;
  logic        pix_valid_q, pix_valid_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic [8:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic        frame_done_q, frame_done_d;
  logic        win_err_q, win_err_d;

  logic        byte_done;
  logic [7:0]  rx_byte;
  logic [15:0] win_start, win_end;

  assign sck_s    = sync2_q[0];
  assign mosi_s   = sync2_q[1];
  assign cs_s     = sync2_q[2];
  assign dc_s     = sync2_q[3];
  assign sck_rise = sck_s & ~sck_prev_q;

  // The 4th window parameter arrives as rx_byte; the first three sit in param_buf.
  assign rx_byte   = {shift_q, mosi_s};
  assign win_start = param_buf_q[23:8];
  assign win_end   = {param_buf_q[7:0], rx_byte};

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    param_idx_d  = param_idx_q;
    param_buf_d  = param_buf_q;
    hi_pending_d = hi_pending_q;
    hi_byte_d    = hi_byte_q;
    col_start_d  = col_start_q;
    col_end_d    = col_end_q;
    row_start_d  = row_start_q;
    row_end_d    = row_end_q;
    col_ptr_d    = col_ptr_q;
    row_ptr_d    = row_ptr_q;
    cmd_code_d   = cmd_code_q;
    pix_data_d   = pix_data_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    cmd_valid_d  = 1'b0;
    pix_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    win_err_d    = 1'b0;
    byte_done    = 1'b0;

    if (cs_s) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise) begin
      shift_d   = rx_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      byte_done = (bit_cnt_q == 3'd7);
    end

    if (byte_done) begin
      if (!dc_s) begin
        cmd_code_d   = rx_byte;
        cmd_valid_d  = 1'b1;
        param_idx_d  = 3'd0;
        hi_pending_d = 1'b0;
        case (rx_byte)
          CMD_CASET: state_d = ST_CASET;
          CMD_PASET: state_d = ST_PASET;
          CMD_RAMWR: begin
            state_d   = ST_RAMWR;
            col_ptr_d = col_start_q;
            row_ptr_d = row_start_q;
          end
          default:   state_d = ST_IDLE;
        endcase
      end else begin
        case (state_q)
          ST_CASET, ST_PASET: begin
            if (param_idx_q < 3'd3) begin
              param_buf_d = {param_buf_q[15:0], rx_byte};
              param_idx_d = param_idx_q + 3'd1;
            end else if (param_idx_q == 3'd3) begin
              param_idx_d = 3'd4;
              if (state_q == ST_CASET) begin
                if (win_start <= win_end && win_end < H_LIMIT) begin
                  col_start_d = win_start[8:0];
                  col_end_d   = win_end[8:0];
                end else begin
                  win_err_d = 1'b1;
                end
              end else begin
                if (win_start <= win_end && win_end < V_LIMIT) begin
                  row_start_d = win_start[8:0];
                  row_end_d   = win_end[8:0];
                end else begin
                  win_err_d = 1'b1;
                end
              end
            end
          end
          ST_RAMWR: begin
            if (!hi_pending_q) begin
              hi_byte_d    = rx_byte;
              hi_pending_d = 1'b1;
            end else begin
              hi_pending_d = 1'b0;
              pix_valid_d  = 1'b1;
              pix_data_d   = {hi_byte_q, rx_byte};
              pix_x_d      = col_ptr_q;
              pix_y_d      = row_ptr_q;
              if (col_ptr_q == col_end_q) begin
                col_ptr_d = col_start_q;
                if (row_ptr_q == row_end_q) begin
                  row_ptr_d    = row_start_q;
                  frame_done_d = 1'b1;
                end else begin
                  row_ptr_d = row_ptr_q + 9'd1;
                end
              end else begin
                col_ptr_d = col_ptr_q + 9'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 4'd0;
      sync2_q      <= 4'd0;
      sck_prev_q   <= 1'b0;
      state_q      <= ST_IDLE;
      shift_q      <= 7'd0;
      bit_cnt_q    <= 3'd0;
      param_idx_q  <= 3'd0;
      param_buf_q  <= 24'd0;
      hi_pending_q <= 1'b0;
      hi_byte_q    <= 8'd0;
      col_start_q  <= 9'd0;
      col_end_q    <= H_LAST;
      row_start_q  <= 9'd0;
      row_end_q    <= V_LAST;
      col_ptr_q    <= 9'd0;
      row_ptr_q    <= 9'd0;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= 8'd0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= 16'd0;
      pix_x_q      <= 9'd0;
      pix_y_q      <= 9'd0;
      frame_done_q <= 1'b0;
      win_err_q    <= 1'b0;
    end else begin
      sync1_q      <= {spi_dc, spi_cs, spi_mosi, spi_sck};
      sync2_q      <= sync1_q;
      sck_prev_q   <= sck_s;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      param_idx_q  <= param_idx_d;
      param_buf_q  <= param_buf_d;
      hi_pending_q <= hi_pending_d;
      hi_byte_q    <= hi_byte_d;
      col_start_q  <= col_start_d;
      col_end_q    <= col_end_d;
      row_start_q  <= row_start_d;
      row_end_q    <= row_end_d;
      col_ptr_q    <= col_ptr_d;
      row_ptr_q    <= row_ptr_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      frame_done_q <= frame_done_d;
      win_err_q    <= win_err_d;
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign frame_done = frame_done_q;
  assign win_err    = win_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ili9341_spi_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ili9341_spi_receiver
// Brief    : Scoreboard bench for ili9341_spi_receiver on a reduced 16x8 panel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ili9341_spi_receiver;

  localparam int H = 16;
  localparam int V = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        cs = 1'b1;
  logic        dc = 1'b0;
  logic        cmd_valid, pix_valid, frame_done, win_err;
  logic [7:0]  cmd_code;
  logic [15:0] pix_data;
  logic [8:0]  pix_x, pix_y;

  ili9341_spi_receiver #(.H_RES(H), .V_RES(V)) dut (
    .clk(clk), .rst(rst),
    .spi_sck(sck), .spi_mosi(mosi), .spi_cs(cs), .spi_dc(dc),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y),
    .frame_done(frame_done), .win_err(win_err)
  );

  always #5 clk = ~clk;

  // kind: 0 = command, 1 = pixel, 2 = window error
  typedef struct {
    int          kind;
    logic [15:0] val;
    logic [8:0]  x;
    logic [8:0]  y;
    logic        fd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp_cmd(input logic [7:0] c);
    exp_t e;
    e.kind = 0; e.val = {8'h00, c}; e.x = 9'd0; e.y = 9'd0; e.fd = 1'b0;
    sb.push_back(e);
  endtask

  task automatic exp_pix(input logic [15:0] v, input int x, input int y, input logic fd);
    exp_t e;
    e.kind = 1; e.val = v; e.x = 9'(x); e.y = 9'(y); e.fd = fd;
    sb.push_back(e);
  endtask

  task automatic exp_err();
    exp_t e;
    e.kind = 2; e.val = 16'd0; e.x = 9'd0; e.y = 9'd0; e.fd = 1'b0;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (frame_done) check_eq("frame_done_with_pix", {31'd0, pix_valid}, 32'd1);
    if (cmd_valid || pix_valid || win_err) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", {29'd0, cmd_valid, pix_valid, win_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.kind == 0) begin
          check_eq("cmd_valid", {31'd0, cmd_valid}, 32'd1);
          check_eq("cmd_code", {24'd0, cmd_code}, {24'd0, e.val[7:0]});
        end else if (e.kind == 1) begin
          check_eq("pix_valid", {31'd0, pix_valid}, 32'd1);
          check_eq("pix_data", {16'd0, pix_data}, {16'd0, e.val});
          check_eq("pix_x", {23'd0, pix_x}, {23'd0, e.x});
          check_eq("pix_y", {23'd0, pix_y}, {23'd0, e.y});
          check_eq("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
        end else begin
          check_eq("win_err", {31'd0, win_err}, 32'd1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      tick(3);
      sck = 1'b1;
      tick(3);
      sck = 1'b0;
    end
  endtask

  task automatic send(input logic d, input logic [7:0] b);
    dc = d;
    cs = 1'b0;
    spi_bits(b, 8);
    tick(2);
  endtask

  task automatic send_cmd(input logic [7:0] c);
    exp_cmd(c);
    send(1'b0, c);
  endtask

  task automatic send_pix(input logic [15:0] v, input int x, input int y, input logic fd);
    exp_pix(v, x, y, fd);
    send(1'b1, v[15:8]);
    send(1'b1, v[7:0]);
  endtask

  task automatic check_reset_values();
    check_eq("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check_eq("rst_cmd_code", {24'd0, cmd_code}, 32'd0);
    check_eq("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    check_eq("rst_pix_data", {16'd0, pix_data}, 32'd0);
    check_eq("rst_pix_x", {23'd0, pix_x}, 32'd0);
    check_eq("rst_pix_y", {23'd0, pix_y}, 32'd0);
    check_eq("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check_eq("rst_win_err", {31'd0, win_err}, 32'd0);
  endtask

  initial begin
    tick(3);
    check_reset_values();
    rst = 1'b0;
    tick(4);

    // First pixel after RAMWR lands at the origin of the default window
    send_cmd(8'h2C);
    send_pix(16'hF800, 0, 0, 1'b0);

    // Reversed column window is rejected and leaves the window alone
    send_cmd(8'h2A);
    exp_err();
    send(1'b1, 8'd0); send(1'b1, 8'd20); send(1'b1, 8'd0); send(1'b1, 8'd10);
    send_cmd(8'h2C);
    send_pix(16'h1234, 0, 0, 1'b0);

    // End equal to the panel size is one past the last legal index
    send_cmd(8'h2A);
    exp_err();
    send(1'b1, 8'd0); send(1'b1, 8'd0); send(1'b1, 8'd0); send(1'b1, 8'(H));
    send_cmd(8'h2B);
    exp_err();
    send(1'b1, 8'd0); send(1'b1, 8'd0); send(1'b1, 8'd0); send(1'b1, 8'(V));

    // Data bytes after an unknown command produce nothing
    send_cmd(8'h00);
    send(1'b1, 8'h55);
    send(1'b1, 8'h66);

    // Partial byte aborted by cs high is discarded
    send_cmd(8'h2C);
    dc = 1'b1;
    cs = 1'b0;
    spi_bits(8'h5A, 5);
    tick(2);
    cs = 1'b1;
    tick(4);
    cs = 1'b0;
    tick(2);
    exp_pix(16'hABAB, 0, 0, 1'b0);
    send(1'b1, 8'hAB);
    send(1'b1, 8'hAB);

    // Whole default frame: one frame_done on the last pixel, then wrap
    send_cmd(8'h2C);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        send_pix(16'((y << 8) | x | 16'h8000), x, y, (x == H - 1) && (y == V - 1));
    send_pix(16'hBEEF, 0, 0, 1'b0);

    // Sub-window 10..12 x 5..6, with a 5th CASET parameter that must be ignored
    send_cmd(8'h2A);
    send(1'b1, 8'd0); send(1'b1, 8'd10); send(1'b1, 8'd0); send(1'b1, 8'd12); send(1'b1, 8'h01);
    send_cmd(8'h2B);
    send(1'b1, 8'd0); send(1'b1, 8'd5); send(1'b1, 8'd0); send(1'b1, 8'd6);
    send_cmd(8'h2C);
    send_pix(16'h0001, 10, 5, 1'b0);
    send_pix(16'h0002, 11, 5, 1'b0);
    send_pix(16'h0003, 12, 5, 1'b0);
    send_pix(16'h0004, 10, 6, 1'b0);
    send_pix(16'h0005, 11, 6, 1'b0);
    send_pix(16'h0006, 12, 6, 1'b1);
    send_pix(16'h0007, 10, 5, 1'b0);

    // Reset in the middle of a pixel drops it and restores reset values
    send_cmd(8'h2C);
    send(1'b1, 8'h12);
    rst = 1'b1;
    tick(1);
    check_reset_values();
    rst = 1'b0;
    tick(3);
    send(1'b1, 8'h34);

    // Window restored to defaults by reset
    send_cmd(8'h2C);
    send_pix(16'h4321, 0, 0, 1'b0);
    send_pix(16'h4322, 1, 0, 1'b0);

    tick(20);
    check_eq("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
